alu_seq_muldiv: RTL and testbench
=================================

Name: alu_seq_muldiv

Overview:
- Parametrised, registered successor of the datapath ALU. Adds full shift/compare set and an iterative unsigned multiply/divide unit with HI/LO registers.
- Sits in the EX stage of the MIPS datapath. The controller issues one operation per start pulse and stalls on busy until done.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8).
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  issue operation; accepted only when busy=0
- aluctl  in  4  operation select
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- shamt  in  SHAMT_W  shift amount (shifts use shamt, never b)
- busy  out  1  high while a mul/div is iterating
- done  out  1  one-cycle pulse: result valid
- result  out  WIDTH  registered result
- zero  out  1  registered (result==0)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Reset: busy=0, done=0, result=0, zero=1, hi=0, lo=0, FSM=IDLE, counter=0. Reset mid-operation aborts the operation; HI/LO are not partially written.
- Opcodes:
  - 0 AND, 1 OR, 2 ADD, 3 XOR, 6 SUB (a-b, modulo 2^WIDTH), 12 NOR.
  - 7 SLT signed, 8 SLTU unsigned; both return 1 or 0, zero-extended.
  - 10 SLL, 11 SRL, 13 SRA by shamt.
  - 14 MFHI (result=hi), 15 MFLO (result=lo).
  - 4 MULTU, 5 DIVU.
  - 9: result=0 with done pulse.
- Single-cycle ops: start in IDLE -> result/zero registered at that edge; done=1 during the next cycle; busy stays 0. Back-to-back starts are allowed every cycle.
- FSM states IDLE, MUL, DIV, FIN:
  - IDLE --start&op4--> MUL; IDLE --start&op5--> DIV. Operands latched, counter=WIDTH, busy=1 from the next cycle.
  - MUL: shift-add, one bit per cycle. DIV: restoring shift-subtract, one quotient bit per cycle. Counter decrements each cycle; at counter==1 -> FIN.
  - FIN: hi/lo written, result=lo, zero=(lo==0), done=1 for that cycle, busy=0, -> IDLE.
  - Total latency: start accepted at edge 0, done high in cycle WIDTH+1.
- MULTU: {hi,lo} = a*b, full 2*WIDTH-bit product.
- DIVU: lo = quotient, hi = remainder.
- DIVU with b=0: lo = all ones, hi = a; still takes full latency.
- start while busy=1: ignored; operands and ops are not queued.
- start in FIN cycle: ignored (busy treated as still set for acceptance).
- Operand changes after acceptance have no effect.
- Single-cycle ops never modify hi/lo. MFHI/MFLO issued the cycle after done return the new values.

Optional Feature:
- ALU_OVF_EN defined: adds output port ovf (1 bit), registered alongside result.
  - ovf=1 on signed two's-complement overflow of ADD (operands same sign, result sign differs) or SUB (operands differ in sign, result sign differs from a).
  - ovf=0 for all other ops; reset value 0. Result is still written on overflow.
- Not defined: no ovf port and no overflow logic; all other behaviour identical.

Test Plan:
- ADD a=5, b=7, start -> next cycle done=1, result=12, zero=0, busy=0. Then SUB a=9, b=9 next cycle -> result=0, zero=1.
- SLT a=0xFFFFFFFF, b=1 -> result=1; SLTU same operands -> result=0. SRA a=0x80000000, shamt=4 -> result=0xF8000000; SRL same -> 0x08000000.
- MULTU a=0x00010000, b=0x00010000 -> busy=1 for cycles 1..32, done in cycle 33, hi=1, lo=0, result=0, zero=1. Then MFHI -> result=1.
- DIVU a=100, b=7 -> done in cycle 33, lo=14, hi=2. DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100.
- During DIVU, pulse start with ADD at cycle 5 -> ignored, single done at cycle 33. Assert reset at cycle 10 of MULTU -> next cycle busy=0, done=0, hi=lo=0, result=0, zero=1.
- ALU_OVF_EN: ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, ovf=1. SUB a=0x80000000, b=1 -> ovf=1. ADD a=1, b=1 -> ovf=0.

Source files
------------

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: registered ALU with iterative unsigned multiply/divide and HI/LO, optional ovf output under ALU_OVF_EN
module alu_seq_muldiv #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         aluctl,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
`ifdef ALU_OVF_EN
  output logic               ovf,
`endif
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] md, acc_hi, acc_lo, alu_res, add_r, sub_r;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo, step_hi, step_lo, trial;
  logic [WIDTH:0]   sum, shifted;
  logic             ge;
`ifdef ALU_OVF_EN
  logic             ovf_n;
`endif
  // single-cycle ALU function
  always_comb begin
    add_r = a + b;
    sub_r = a - b;
    case (aluctl)
      4'd0:    alu_res = a & b;
      4'd1:    alu_res = a | b;
      4'd2:    alu_res = add_r;
      4'd3:    alu_res = a ^ b;
      4'd6:    alu_res = sub_r;
      4'd7:    alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'd8:    alu_res = {{(WIDTH-1){1'b0}}, a < b};
      4'd10:   alu_res = a << shamt;
      4'd11:   alu_res = a >> shamt;
      4'd12:   alu_res = ~(a | b);
      4'd13:   alu_res = $signed(a) >>> shamt;
      4'd14:   alu_res = hi;
      4'd15:   alu_res = lo;
      default: alu_res = '0;
    endcase
`ifdef ALU_OVF_EN
    ovf_n = aluctl == 4'd2 ? (a[WIDTH-1] == b[WIDTH-1]) && (add_r[WIDTH-1] != a[WIDTH-1]) :
            aluctl == 4'd6 ? (a[WIDTH-1] != b[WIDTH-1]) && (sub_r[WIDTH-1] != a[WIDTH-1]) : 1'b0;
`endif
  end
  // one multiply (shift-add) or restoring-divide iteration on {acc_hi, acc_lo}
  always_comb begin
    sum              = {1'b0, acc_hi} + {1'b0, md};
    {mul_hi, mul_lo} = acc_lo[0] ? {sum, acc_lo[WIDTH-1:1]} : {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
    shifted          = {acc_hi, acc_lo[WIDTH-1]};
    ge               = shifted >= {1'b0, md};
    trial            = shifted[WIDTH-1:0] - md;
    div_hi           = ge ? trial : shifted[WIDTH-1:0];
    div_lo           = {acc_lo[WIDTH-2:0], ge};
    step_hi          = state == MUL ? mul_hi : div_hi;
    step_lo          = state == MUL ? mul_lo : div_lo;
  end
  // control FSM with registered outputs; HI/LO only change on the final iteration
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b1;
      hi     <= '0;
      lo     <= '0;
      md     <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
`ifdef ALU_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (aluctl == 4'd4 || aluctl == 4'd5) begin
            state  <= aluctl == 4'd4 ? MUL : DIV;
            busy   <= 1'b1;
            cnt    <= CW'(WIDTH);
            md     <= aluctl == 4'd4 ? a : b;
            acc_lo <= aluctl == 4'd4 ? b : a;
            acc_hi <= '0;
          end else begin
            result <= alu_res;
            zero   <= alu_res == '0;
            done   <= 1'b1;
`ifdef ALU_OVF_EN
            ovf    <= ovf_n;
`endif
          end
        end
        MUL, DIV: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state  <= FIN;
            busy   <= 1'b0;
            done   <= 1'b1;
            hi     <= step_hi;
            lo     <= step_lo;
            result <= step_lo;
            zero   <= step_lo == '0;
`ifdef ALU_OVF_EN
            ovf    <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// tb_alu_seq_muldiv: randomized check of alu_seq_muldiv against an arithmetic reference model
module tb_alu_seq_muldiv;
  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0;
  logic [3:0]  aluctl = '0;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  shamt = '0;
  logic        busy, done, zero;
  logic [31:0] result, hi, lo;
`ifdef ALU_OVF_EN
  logic        ovf;
`endif
  int total = 0, passed = 0;
  logic        m_busy, m_done, m_zero, m_ovf, fin;
  logic [31:0] m_res, m_hi, m_lo, p_hi, p_lo;
  int          pend;

  always #5 clk = ~clk;

  alu_seq_muldiv #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .aluctl(aluctl), .a(a), .b(b), .shamt(shamt),
    .busy(busy), .done(done), .result(result), .zero(zero),
`ifdef ALU_OVF_EN
    .ovf(ovf),
`endif
    .hi(hi), .lo(lo));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] single(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input logic [4:0] sh);
    logic signed [31:0] sx;
    sx = x;
    case (op)
      4'd0:    return x & y;
      4'd1:    return x | y;
      4'd2:    return x + y;
      4'd3:    return x ^ y;
      4'd6:    return x - y;
      4'd7:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd8:    return (x < y) ? 32'd1 : 32'd0;
      4'd10:   return x << sh;
      4'd11:   return x >> sh;
      4'd12:   return ~(x | y);
      4'd13:   return sx >>> sh;
      4'd14:   return m_hi;
      4'd15:   return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ovf_of(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    longint s;
    s = op == 4'd2 ? longint'($signed(x)) + longint'($signed(y)) : longint'($signed(x)) - longint'($signed(y));
    return (op == 4'd2 || op == 4'd6) && (s > 64'sd2147483647 || s < -64'sd2147483648);
  endfunction

  task automatic model_step();
    if (reset) begin
      m_busy = 0; m_done = 0; m_res = 0; m_zero = 1; m_hi = 0; m_lo = 0; m_ovf = 0; pend = 0; fin = 0;
    end else begin
      m_done = 0;
      if (fin) fin = 0;
      else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_res = p_lo; m_zero = (p_lo == 0);
          m_done = 1; m_busy = 0; m_ovf = 0; fin = 1;
        end
      end else if (start) begin
        if (aluctl == 4'd4) begin
          {p_hi, p_lo} = 64'(a) * 64'(b);
          pend = 32; m_busy = 1;
        end else if (aluctl == 4'd5) begin
          if (b == 0) begin p_hi = a; p_lo = 32'hFFFF_FFFF; end
          else begin p_hi = a % b; p_lo = a / b; end
          pend = 32; m_busy = 1;
        end else begin
          m_res = single(aluctl, a, b, shamt);
          m_zero = (m_res == 0);
          m_done = 1;
          m_ovf = ovf_of(aluctl, a, b);
        end
      end
    end
  endtask

  task automatic compare();
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("result", result, m_res);
    chk("zero", {31'd0, zero}, {31'd0, m_zero});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
`ifdef ALU_OVF_EN
    chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input logic s, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input logic [4:0] sh);
    start = s; aluctl = op; a = x; b = y; shamt = sh;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)));
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("rst_zero", {31'd0, zero}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 0;
    drive(1, 4'd2, 5, 7, 0);
    chk("add_res", result, 32'd12);
    chk("add_done", {31'd0, done}, 32'd1);
    drive(1, 4'd6, 9, 9, 0);
    chk("sub_res", result, 32'd0);
    chk("sub_zero", {31'd0, zero}, 32'd1);
    drive(1, 4'd7, 32'hFFFF_FFFF, 1, 0);
    chk("slt", result, 32'd1);
    drive(1, 4'd8, 32'hFFFF_FFFF, 1, 0);
    chk("sltu", result, 32'd0);
    drive(1, 4'd13, 32'h8000_0000, 0, 4);
    chk("sra", result, 32'hF800_0000);
    drive(1, 4'd11, 32'h8000_0000, 0, 4);
    chk("srl", result, 32'h0800_0000);
    drive(1, 4'd4, 32'h0001_0000, 32'h0001_0000, 0);
    chk("mul_busy1", {31'd0, busy}, 32'd1);
    idle(31);
    chk("mul_busy32", {31'd0, busy}, 32'd1);
    idle(1);
    chk("mul_done", {31'd0, done}, 32'd1);
    chk("mul_hi", hi, 32'd1);
    chk("mul_lo", lo, 32'd0);
    chk("mul_zero", {31'd0, zero}, 32'd1);
    drive(1, 4'd2, 1, 1, 0);
    chk("fin_ignored", {31'd0, done}, 32'd0);
    drive(1, 4'd14, 0, 0, 0);
    chk("mfhi", result, 32'd1);
    drive(1, 4'd5, 100, 7, 0);
    idle(32);
    chk("div_lo", lo, 32'd14);
    chk("div_hi", hi, 32'd2);
    idle(1);
    drive(1, 4'd5, 100, 0, 0);
    idle(32);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'd100);
    idle(1);
    drive(1, 4'd5, 1000, 3, 0);
    idle(4);
    drive(1, 4'd2, 1, 2, 0);
    idle(27);
    chk("div_ign_done", {31'd0, done}, 32'd1);
    chk("div_ign_lo", lo, 32'd333);
    chk("div_ign_hi", hi, 32'd1);
    idle(1);
    drive(1, 4'd4, 7, 9, 0);
    idle(9);
    reset = 1;
    drive(0, 0, 0, 0, 0);
    reset = 0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_res", result, 32'd0);
    chk("abort_zero", {31'd0, zero}, 32'd1);
`ifdef ALU_OVF_EN
    drive(1, 4'd2, 32'h7FFF_FFFF, 1, 0);
    chk("ovf_add", {31'd0, ovf}, 32'd1);
    chk("ovf_add_res", result, 32'h8000_0000);
    drive(1, 4'd6, 32'h8000_0000, 1, 0);
    chk("ovf_sub", {31'd0, ovf}, 32'd1);
    drive(1, 4'd2, 1, 1, 0);
    chk("ovf_none", {31'd0, ovf}, 32'd0);
`endif
    for (int i = 0; i < 700; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 9) < 7, 4'($urandom_range(0, 15)), rnd(), rnd(), 5'($urandom_range(0, 31)));
    end
    reset = 0;
    idle(40);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
